// File: rtl/keccak_squeeze_stream.sv
// Keccak squeeze-side controller: streams rate lanes of a permuted state as
// 64-bit words over valid/ready and requests a fresh permutation each time
// the rate portion is used up, until the requested word count is delivered.
module keccak_squeeze_stream #(
  parameter int RATE_LANES = 21,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] req_words,
  input  logic [1599:0]    state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic             perm_req,
  output logic [1599:0]    perm_state_out,
  input  logic             perm_ack,
  input  logic [1599:0]    perm_state_in,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  typedef enum logic [1:0] {IDLE, EMIT, PERM} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [1599:0]    st;
  logic [4:0]       word_idx;
  logic [CNT_W-1:0] remaining;
  logic             done_q;
  logic             hs;
  logic             final_word;

  assign hs         = (fsm == EMIT) & out_ready;
  assign final_word = (remaining == CNT_W'(1));
  assign done       = done_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // Next-state logic; abort overrides everything, final word beats rate wrap
  always_comb begin
    fsm_nxt = fsm;
    if (abort) begin
      fsm_nxt = IDLE;
    end else begin
      case (fsm)
        IDLE: if (start && req_words != '0) fsm_nxt = EMIT;
        EMIT: if (hs) begin
          if (final_word)                fsm_nxt = IDLE;
          else if (word_idx == LAST_IDX) fsm_nxt = PERM;
        end
        PERM: if (perm_ack) fsm_nxt = EMIT;
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state; data buses are zero when not valid
  always_comb begin
    out_valid      = (fsm == EMIT);
    out_data       = '0;
    out_last       = 1'b0;
    perm_req       = (fsm == PERM);
    perm_state_out = '0;
    busy           = (fsm != IDLE);
    if (fsm == EMIT) begin
      out_data = st[{word_idx, 6'b0} +: 64];
      out_last = final_word;
    end
    if (fsm == PERM) perm_state_out = st;
  end

  // Datapath: latched state, lane index, remaining count and the done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= '0;
      word_idx  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else if (abort) begin
      done_q    <= 1'b0;
      remaining <= '0;
      word_idx  <= '0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: if (start) begin
          if (req_words != '0) begin
            st        <= state_in;
            word_idx  <= '0;
            remaining <= req_words;
          end else begin
            done_q <= 1'b1;
          end
        end
        EMIT: if (hs) begin
          if (remaining != '0) remaining <= remaining - CNT_W'(1);
          if (final_word)                done_q   <= 1'b1;
          else if (word_idx != LAST_IDX) word_idx <= word_idx + 5'd1;
        end
        PERM: if (perm_ack) begin
          st       <= perm_state_in;
          word_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
